// File: rtl/alu_issue_unit.sv
// Command front-end for the 8-bit ALU: FIFO-buffered commands, combinational
// ALU drive from the FIFO head, registered result/flags output and accumulator.
module alu_issue_unit #(
   parameter int          DEPTH     = 4,
   parameter logic [7:0]  ACC_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic       in_use_acc,
   input  logic       acc_clr,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_op,
   input  logic [7:0] alu_result,
   input  logic [3:0] alu_flags,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_result,
   output logic [3:0] out_flags,
   output logic [7:0] acc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       use_acc;
   } cmd_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic          ready_en;
   logic          push;
   logic          issue;

   // Handshake: a transfer occurs on any rising edge where valid and ready are
   // both high; valid must not depend on ready, and ready never depends on
   // same-cycle valid (in_ready ignores a pop happening in the same cycle).
   assign in_ready = ready_en && (count < DEPTH_C);
   assign push     = in_valid && in_ready;
   assign issue    = (count != '0) && (!out_valid || out_ready);

   assign head   = mem[rptr];
   assign alu_op = head.op;
   assign alu_b  = head.b;
   assign alu_a  = head.use_acc ? acc : head.a;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= '{op: in_op, a: in_a, b: in_b, use_acc: in_use_acc};
      end
   end

   // ready_en keeps in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en   <= 1'b0;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         out_result <= 8'h00;
         out_flags  <= 4'h0;
         acc        <= ACC_RESET;
      end else begin
         ready_en <= 1'b1;
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (issue) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, issue})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // A retiring command beats acc_clr; the producer must re-issue the clear.
         if (issue) begin
            out_result <= alu_result;
            out_flags  <= alu_flags;
            out_valid  <= 1'b1;
            acc        <= alu_result;
         end else begin
            if (out_valid && out_ready) begin
               out_valid <= 1'b0;
            end
            if (acc_clr) begin
               acc <= ACC_RESET;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a behavioural 8-bit ALU closes the loop, directed
// vectors cover the single-command cases, sequences cover multi-cycle behaviour.
module tb_alu_issue_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_use_acc;
   logic       acc_clr;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] alu_op;
   logic [7:0] alu_result;
   logic [3:0] alu_flags;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic [3:0] out_flags;
   logic [7:0] acc;

   int n_pass  = 0;
   int n_total = 0;

   logic [11:0] exp_q[$];

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       ua;
      logic [7:0] r;
      logic [3:0] f;
      logic [7:0] acc;
   } vec_t;

   vec_t vecs [10];

   alu_issue_unit #(.DEPTH(4), .ACC_RESET(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_use_acc(in_use_acc),
      .acc_clr(acc_clr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .acc(acc)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU: 0 add, 1 sub (carry = no borrow), 2 mul, 3 div, others xor.
   // Returns {carry, negative, overflow, zero, result}.
   function automatic logic [11:0] alu_model(input logic [3:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
      logic [8:0]  s;
      logic [15:0] p;
      logic [7:0]  r;
      logic        c;
      logic        v;
      logic        dz;
      c  = 1'b0;
      v  = 1'b0;
      dz = 1'b0;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         4'd1: begin
            r = a - b;
            c = (a >= b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         4'd2: begin
            p = a * b;
            r = p[7:0];
            c = |p[15:8];
         end
         4'd3: begin
            if (b == 8'h00) begin
               r  = 8'hff;
               dz = 1'b1;
            end else begin
               r = a / b;
            end
         end
         default: r = a ^ b;
      endcase
      if (dz) return {4'b0001, r};
      return {c, r[7], v, (r == 8'h00), r};
   endfunction

   assign {alu_flags, alu_result} = alu_model(alu_op, alu_a, alu_b);

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_cmd(input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic ua);
      in_valid   = 1'b1;
      in_op      = op;
      in_a       = a;
      in_b       = b;
      in_use_acc = ua;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int accepted;
      int sent;
      int got;
      int cyc;
      int fm;
      logic ov_m;
      logic stale;
      logic push_m;
      logic issue_m;
      logic [11:0] e;

      vecs[0] = '{4'd0,  8'd20,  8'd10,  1'b0, 8'd30,  4'b0000, 8'd30};
      vecs[1] = '{4'd0,  8'd250, 8'd10,  1'b0, 8'd4,   4'b1000, 8'd4};
      vecs[2] = '{4'd3,  8'd50,  8'd0,   1'b0, 8'hff,  4'b0001, 8'hff};
      vecs[3] = '{4'd1,  8'd0,   8'h0f,  1'b1, 8'hf0,  4'b1100, 8'hf0};
      vecs[4] = '{4'd0,  8'd100, 8'd100, 1'b0, 8'hc8,  4'b0110, 8'hc8};
      vecs[5] = '{4'd1,  8'd7,   8'd7,   1'b0, 8'h00,  4'b1001, 8'h00};
      vecs[6] = '{4'd2,  8'd16,  8'd16,  1'b0, 8'h00,  4'b1001, 8'h00};
      vecs[7] = '{4'd5,  8'haa,  8'h55,  1'b0, 8'hff,  4'b0100, 8'hff};
      vecs[8] = '{4'd0,  8'd0,   8'd1,   1'b1, 8'h00,  4'b1001, 8'h00};
      vecs[9] = '{4'd15, 8'd77,  8'h3c,  1'b1, 8'h3c,  4'b0000, 8'h3c};

      // ---------------- reset ----------------
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_op      = 4'd0;
      in_a       = 8'd0;
      in_b       = 8'd0;
      in_use_acc = 1'b0;
      acc_clr    = 1'b0;
      out_ready  = 1'b1;
      step();
      step();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_flags", out_flags, 0);
      check("rst_acc", acc, 0);
      check("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1 check("in_ready_before_first_edge", in_ready, 0);
      step();
      check("in_ready_after_first_edge", in_ready, 1);

      // ---------------- table-driven single commands ----------------
      for (int i = 0; i < 10; i++) begin
         drive_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua);
         step();
         in_valid = 1'b0;
         check($sformatf("v%0d_no_bypass", i), out_valid, 0);
         step();
         check($sformatf("v%0d_valid", i), out_valid, 1);
         check($sformatf("v%0d_result", i), out_result, vecs[i].r);
         check($sformatf("v%0d_flags", i), out_flags, vecs[i].f);
         check($sformatf("v%0d_acc", i), acc, vecs[i].acc);
      end

      // ---------------- back-to-back accumulator chaining ----------------
      drive_cmd(4'd0, 8'd5, 8'd3, 1'b0);
      step();
      drive_cmd(4'd2, 8'd0, 8'd4, 1'b1);
      step();
      check("chain0_valid", out_valid, 1);
      check("chain0", {out_flags, out_result}, {4'b0000, 8'd8});
      drive_cmd(4'd1, 8'd0, 8'd40, 1'b1);
      step();
      in_valid = 1'b0;
      check("chain1_valid", out_valid, 1);
      check("chain1", {out_flags, out_result}, {4'b0000, 8'd32});
      step();
      check("chain2_valid", out_valid, 1);
      check("chain2", {out_flags, out_result}, {4'b0100, 8'd248});
      check("chain_acc", acc, 8'd248);

      // ---------------- acc_clr idle and acc_clr lost to issue ----------------
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      check("acc_clr_idle", acc, 8'h00);
      drive_cmd(4'd0, 8'd3, 8'd4, 1'b0);
      step();
      in_valid = 1'b0;
      acc_clr  = 1'b1;
      step();
      acc_clr = 1'b0;
      check("acc_clr_lost", acc, 8'd7);
      check("acc_clr_lost_result", out_result, 8'd7);
      step();

      // ---------------- backpressure fill ----------------
      out_ready = 1'b0;
      accepted  = 0;
      for (int i = 0; i < 6; i++) begin
         drive_cmd(4'd0, 8'(i * 10), 8'd1, 1'b0);
         if (in_ready) begin
            accepted++;
            exp_q.push_back({4'b0000, 8'(i * 10 + 1)});
         end
         step();
      end
      in_valid = 1'b0;
      check("bp_accepted", accepted, 5);
      check("bp_full_ready", in_ready, 0);
      step();
      check("bp_still_full", in_ready, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
         check($sformatf("bp_valid%0d", k), out_valid, 1);
         check($sformatf("bp_result%0d", k), {out_flags, out_result}, e);
         if (k == 0) check("bp_ready_before_pop", in_ready, 0);
         if (k == 1) check("bp_ready_after_pop", in_ready, 1);
         step();
      end
      check("bp_drained", out_valid, 0);

      // ---------------- wrap-around with random backpressure ----------------
      exp_q.delete();
      sent = 0;
      got  = 0;
      cyc  = 0;
      fm   = 0;
      ov_m = 1'b0;
      while (got < 12 && cyc < 300) begin
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
            check($sformatf("wrap_result%0d", got), {out_flags, out_result}, e);
            got++;
         end
         check("wrap_in_ready", in_ready, (fm < 4));
         if (sent < 12) begin
            drive_cmd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 1'b0);
            if (in_ready) begin
               exp_q.push_back(alu_model(in_op, in_a, in_b));
               sent++;
            end
         end else begin
            in_valid = 1'b0;
         end
         issue_m = (fm != 0) && (!ov_m || out_ready);
         push_m  = in_valid && (fm < 4);
         fm      = fm + int'(push_m) - int'(issue_m);
         if (issue_m) ov_m = 1'b1;
         else if (ov_m && out_ready) ov_m = 1'b0;
         cyc++;
         step();
      end
      in_valid = 1'b0;
      check("wrap_all_received", got, 12);
      check("wrap_queue_empty", exp_q.size(), 0);
      out_ready = 1'b1;
      step();
      step();

      // ---------------- reset mid-stream ----------------
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_cmd(4'd0, 8'd9, 8'(9 + i), 1'b0);
         step();
      end
      in_valid = 1'b0;
      check("mid_valid_before_reset", out_valid, 1);
      check("mid_acc_before_reset", acc, 8'd18);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_acc", acc, 8'h00);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_out_result", out_result, 8'h00);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      stale     = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (out_valid) stale = 1'b1;
      end
      check("mid_no_stale_output", stale, 0);
      check("mid_ready_after_release", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
